pcr_unit: RTL and testbench
===========================

# pcr_unit

Platform control register (PCR) target that sits directly downstream of the core's PCR request port. It accepts one request at a time over a valid/ready handshake and applies read, write, set or clear operations to a small register bank. The bank holds a free-running cycle counter, an accepted-request counter and read/write scratch registers. After a fixed latency it returns a single-cycle response, carrying the old register value and the echoed core id, to the core's PCR response inputs.

## Interface
- NUM_REGS, 8: number of bank entries (≥3). Index 0 is the cycle counter, index 1 is the request counter, the rest are scratch.
- BASE_ADDR, 12'h7C0: address of index 0.
- RESP_LATENCY, 2: cycles from accept to response (≥1).

Ports:
- clk_i  in  1  clock; all logic is on the rising edge.
- rstn_i  in  1  reset; asynchronous, active-low.
- pcr_req_valid_i  in  1  request valid.
- pcr_req_ready_o  out  1  unit can accept a request.
- pcr_req_addr_i  in  12  register address.
- pcr_req_data_i  in  64  write, set or clear operand.
- pcr_req_we_i  in  3  command: 000 read, 001 write, 010 set bits, 011 clear bits, others treated as read.
- pcr_req_core_id_i  in  1  requester id.
- pcr_resp_valid_o  out  1  one-cycle response pulse.
- pcr_resp_data_o  out  64  register value before the operation.
- pcr_resp_core_id_o  out  1  echoed requester id.

## Operation
- FSM states are IDLE, WAIT and RESP.
- **IDLE:** pcr_req_ready_o=1. On valid&ready the unit accepts the request.
  - If RESP_LATENCY==1 it goes to RESP; otherwise it goes to WAIT and loads the latency counter with RESP_LATENCY-1.
- **WAIT:** ready=0. The counter decrements each cycle; when it reaches 1 the unit goes to RESP.
- **RESP:** ready=0, pcr_resp_valid_o=1 for exactly one cycle, then IDLE.
- **Decode:** idx = addr - BASE_ADDR. The access hits only when BASE_ADDR ≤ addr < BASE_ADDR+NUM_REGS. A miss reads 0 and has no side effect.
- **At the accept edge:**
  - The response data register captures the current value of the entry, before this cycle's increment or write.
  - The core id is captured.
  - The write, set or clear is applied: new = data, old|data, or old&~data.
- **Counters:**
  - Index 0: the cycle counter increments every cycle after reset, wraps at 2^64, and ignores writes.
  - Index 1: the request counter increments by 1 on every accepted request, hit or miss, wraps at 2^64, and ignores writes.
- pcr_resp_data_o and pcr_resp_core_id_o are held stable from capture until the next accept. They are only meaningful while valid=1.
- Request inputs outside an accept cycle are ignored. There is no queueing, and a request held high during WAIT or RESP waits for IDLE.

## Timing
- **Reset values:**
  - State = IDLE, so pcr_req_ready_o=1.
  - pcr_resp_valid_o=0, pcr_resp_data_o=0, pcr_resp_core_id_o=0.
  - Both counters and all scratch registers = 0.
- **Latency:** an accept on edge T gives pcr_resp_valid_o=1 in the cycle after edge T+RESP_LATENCY-1, i.e. RESP_LATENCY cycles after the accept cycle.
- **Throughput:** one request per RESP_LATENCY+1 cycles. ready returns to 1 in the cycle after RESP.
- **Read-after-write:** a write accepted on one request is visible to the next request's read.
- **Reset asserted mid-transaction:** the in-flight request is dropped, valid goes to 0 immediately (asynchronously), and no response is ever produced for it.
- **Same-cycle write and increment:** the counters have no write path, so the increment always wins.

## Test plan
- **Reset then scratch write and read** (RESP_LATENCY=2): write 0xDEAD_BEEF to 0x7C2 → response 2 cycles later with data 0. A subsequent read of 0x7C2 returns 0xDEAD_BEEF with the same core id echoed. ready is low for 2 cycles after each accept.
- **Set/clear:** scratch at 0x7C3=0xF0, then set 0x0F → returns 0xF0. Clear 0xFF → returns 0xFF. A final read returns 0.
- **Cycle counter:** read 0x7C0 accepted on the 10th edge after reset deassertion → data 9. Writing 0x1234 to 0x7C0 has no effect; a later read returns a value that keeps increasing.
- **Out-of-range and request count:** a write to 0x7C8 and a read of 0x100 both return 0. Reading 0x7C1 afterwards returns 2 (both misses counted).
- **Back-to-back hold:** valid held high with 3 consecutive reads → accepts are spaced exactly 3 cycles apart, and exactly one valid pulse is produced per accept.
- **Reset mid-WAIT:** assert rstn_i low during WAIT → valid stays 0, ready=1 after release, and all scratch registers read 0.

Source files
------------

// File: rtl/pcr_unit.sv
// Platform control register target: one outstanding read/write/set/clear request against a
// small bank holding a cycle counter, a request counter and scratch registers.
module pcr_unit #(
    parameter int unsigned NUM_REGS     = 8,
    parameter logic [11:0] BASE_ADDR    = 12'h7C0,
    parameter int unsigned RESP_LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        pcr_req_valid_i,
    output logic        pcr_req_ready_o,
    input  logic [11:0] pcr_req_addr_i,
    input  logic [63:0] pcr_req_data_i,
    input  logic [2:0]  pcr_req_we_i,
    input  logic        pcr_req_core_id_i,
    output logic        pcr_resp_valid_o,
    output logic [63:0] pcr_resp_data_o,
    output logic        pcr_resp_core_id_o
);
    localparam int unsigned IdxW = $clog2(NUM_REGS);
    localparam int unsigned CntW = $clog2(RESP_LATENCY + 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [63:0]     regs_q [NUM_REGS];
    logic [63:0]     regs_d [NUM_REGS];
    logic [63:0]     resp_data_q;
    logic            resp_core_id_q;

    logic            accept;
    logic            hit;
    logic [11:0]     offset;
    logic [IdxW-1:0] idx;
    logic [63:0]     old_val;
    logic [63:0]     new_val;

    assign accept = pcr_req_valid_i && (state_q == StIdle);
    assign offset = pcr_req_addr_i - BASE_ADDR;
    assign hit    = (pcr_req_addr_i >= BASE_ADDR) && (32'(offset) < NUM_REGS);
    assign idx    = offset[IdxW-1:0];

    always_comb begin
        old_val = '0;
        if (hit) begin
            old_val = regs_q[idx];
        end
    end

    always_comb begin
        new_val = old_val;
        case (pcr_req_we_i)
            3'b001:  new_val = pcr_req_data_i;
            3'b010:  new_val = old_val | pcr_req_data_i;
            3'b011:  new_val = old_val & ~pcr_req_data_i;
            default: new_val = old_val;
        endcase
    end

    // Counters are assigned after the scratch write so they can never be overwritten.
    always_comb begin
        regs_d = regs_q;
        if (accept && hit && (32'(idx) >= 32'd2)) begin
            regs_d[idx] = new_val;
        end
        regs_d[0] = regs_q[0] + 64'd1;
        if (accept) begin
            regs_d[1] = regs_q[1] + 64'd1;
        end
    end

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        pcr_req_ready_o  = 1'b0;
        pcr_resp_valid_o = 1'b0;
        unique case (state_q)
            StIdle: begin
                pcr_req_ready_o = 1'b1;
                if (pcr_req_valid_i) begin
                    if (RESP_LATENCY == 1) begin
                        state_d = StResp;
                    end else begin
                        state_d = StWait;
                        cnt_d   = CntW'(RESP_LATENCY - 1);
                    end
                end
            end
            StWait: begin
                if (cnt_q == CntW'(1)) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StResp: begin
                pcr_resp_valid_o = 1'b1;
                state_d          = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            resp_data_q    <= '0;
            resp_core_id_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            regs_q  <= regs_d;
            if (accept) begin
                resp_data_q    <= old_val;
                resp_core_id_q <= pcr_req_core_id_i;
            end
        end
    end

    assign pcr_resp_data_o    = resp_data_q;
    assign pcr_resp_core_id_o = resp_core_id_q;

endmodule

// File: tb/tb_pcr_unit.sv
// Directed and randomized bench for pcr_unit against a transaction-level model of the bank.
module tb_pcr_unit;
    localparam int unsigned NUM_REGS     = 8;
    localparam logic [11:0] BASE_ADDR    = 12'h7C0;
    localparam int unsigned RESP_LATENCY = 2;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [11:0] req_addr = '0;
    logic [63:0] req_data = '0;
    logic [2:0]  req_we = '0;
    logic        req_cid = 1'b0;
    logic        resp_valid;
    logic [63:0] resp_data;
    logic        resp_cid;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: edges since reset release, accepted requests, scratch contents.
    longint unsigned edges;
    longint unsigned m_reqs;
    logic [63:0]     m_scratch [NUM_REGS];

    pcr_unit #(
        .NUM_REGS    (NUM_REGS),
        .BASE_ADDR   (BASE_ADDR),
        .RESP_LATENCY(RESP_LATENCY)
    ) dut (
        .clk_i             (clk),
        .rstn_i            (rstn),
        .pcr_req_valid_i   (req_valid),
        .pcr_req_ready_o   (req_ready),
        .pcr_req_addr_i    (req_addr),
        .pcr_req_data_i    (req_data),
        .pcr_req_we_i      (req_we),
        .pcr_req_core_id_i (req_cid),
        .pcr_resp_valid_o  (resp_valid),
        .pcr_resp_data_o   (resp_data),
        .pcr_resp_core_id_o(resp_cid)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) edges <= 0;
        else       edges <= edges + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_reqs = 0;
        for (int i = 0; i < NUM_REGS; i++) m_scratch[i] = '0;
    endtask

    // Value returned for a request accepted at the coming edge, then apply its side effects.
    task automatic model_access(input logic [11:0] addr, input logic [63:0] data,
                                input logic [2:0] we, output logic [63:0] old);
        int off;
        off = int'(addr) - int'(BASE_ADDR);
        old = '0;
        if (off >= 0 && off < int'(NUM_REGS)) begin
            if (off == 0)      old = edges;
            else if (off == 1) old = m_reqs;
            else begin
                old = m_scratch[off];
                if (we == 3'd1)      m_scratch[off] = data;
                else if (we == 3'd2) m_scratch[off] = old | data;
                else if (we == 3'd3) m_scratch[off] = old & ~data;
            end
        end
        m_reqs++;
    endtask

    // Called at a negedge with the unit idle; returns at a negedge with the unit idle again.
    task automatic transact(input string tag, input logic [11:0] addr, input logic [63:0] data,
                            input logic [2:0] we, input logic cid, output logic [63:0] obs);
        logic [63:0] exp;
        check({tag, "_ready_idle"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_addr  = addr;
        req_data  = data;
        req_we    = we;
        req_cid   = cid;
        model_access(addr, data, we, exp);
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 1; i < int'(RESP_LATENCY); i++) begin
            check({tag, "_ready_wait"}, 64'(req_ready), 64'd0);
            check({tag, "_valid_wait"}, 64'(resp_valid), 64'd0);
            @(negedge clk);
        end
        check({tag, "_valid"}, 64'(resp_valid), 64'd1);
        check({tag, "_ready_resp"}, 64'(req_ready), 64'd0);
        check({tag, "_data"}, resp_data, exp);
        check({tag, "_cid"}, 64'(resp_cid), 64'(cid));
        obs = resp_data;
        @(negedge clk);
        check({tag, "_valid_end"}, 64'(resp_valid), 64'd0);
        check({tag, "_ready_end"}, 64'(req_ready), 64'd1);
    endtask

    task automatic do_reset(input string tag);
        rstn = 1'b0;
        req_valid = 1'b0;
        #1;
        check({tag, "_rst_ready"}, 64'(req_ready), 64'd1);
        check({tag, "_rst_valid"}, 64'(resp_valid), 64'd0);
        check({tag, "_rst_data"}, resp_data, 64'd0);
        check({tag, "_rst_cid"}, 64'(resp_cid), 64'd0);
        model_clear();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        logic [63:0] obs;
        logic [63:0] c1;
        logic [63:0] c2;
        int          pulses;
        logic [11:0] a;

        model_clear();
        @(negedge clk);
        do_reset("init");

        // Scratch write then read-back.
        transact("wr_scr", 12'h7C2, 64'hDEAD_BEEF, 3'd1, 1'b1, obs);
        check("wr_scr_old0", obs, 64'd0);
        transact("rd_scr", 12'h7C2, 64'd0, 3'd0, 1'b1, obs);
        check("rd_scr_val", obs, 64'hDEAD_BEEF);

        // Set and clear.
        transact("sc_wr", 12'h7C3, 64'hF0, 3'd1, 1'b0, obs);
        transact("sc_set", 12'h7C3, 64'h0F, 3'd2, 1'b0, obs);
        check("sc_set_old", obs, 64'hF0);
        transact("sc_clr", 12'h7C3, 64'hFF, 3'd3, 1'b1, obs);
        check("sc_clr_old", obs, 64'hFF);
        transact("sc_rd", 12'h7C3, 64'd0, 3'd0, 1'b0, obs);
        check("sc_rd_zero", obs, 64'd0);

        // Out-of-range accesses still count as requests.
        do_reset("oor");
        transact("oor_wr", 12'h7C8, 64'h55, 3'd1, 1'b0, obs);
        check("oor_wr_zero", obs, 64'd0);
        transact("oor_rd", 12'h100, 64'd0, 3'd0, 1'b1, obs);
        check("oor_rd_zero", obs, 64'd0);
        transact("reqcnt", 12'h7C1, 64'd0, 3'd0, 1'b0, obs);
        check("reqcnt_two", obs, 64'd2);

        // Cycle counter: accept on the 10th edge after release.
        do_reset("cyc");
        repeat (9) @(negedge clk);
        transact("cyc_rd", 12'h7C0, 64'd0, 3'd0, 1'b1, c1);
        check("cyc_nine", c1, 64'd9);
        transact("cyc_wr", 12'h7C0, 64'h1234, 3'd1, 1'b0, obs);
        repeat (3) @(negedge clk);
        transact("cyc_rd2", 12'h7C0, 64'd0, 3'd0, 1'b0, c2);
        check("cyc_incr", 64'(c2 > c1), 64'd1);

        // Back-to-back hold: valid stays high across three accepts.
        transact("b2b_wr", 12'h7C5, 64'hA5A5, 3'd1, 1'b0, obs);
        pulses    = 0;
        req_valid = 1'b1;
        req_addr  = 12'h7C5;
        req_we    = 3'd0;
        req_cid   = 1'b1;
        for (int k = 0; k < 9; k++) begin
            check("b2b_ready", 64'(req_ready), 64'((k % 3) == 0));
            check("b2b_valid", 64'(resp_valid), 64'((k % 3) == 2));
            if (resp_valid) begin
                pulses++;
                check("b2b_data", resp_data, m_scratch[5]);
            end
            if ((k % 3) == 0) m_reqs++;
            @(negedge clk);
            if (k == 6) req_valid = 1'b0;
        end
        check("b2b_pulses", 64'(pulses), 64'd3);
        transact("b2b_cnt", 12'h7C1, 64'd0, 3'd0, 1'b0, obs);

        // Reset during WAIT drops the request.
        check("mid_ready0", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_addr  = 12'h7C4;
        req_data  = 64'h1111;
        req_we    = 3'd1;
        @(negedge clk);
        req_valid = 1'b0;
        check("mid_in_wait", 64'(req_ready), 64'd0);
        do_reset("mid");
        for (int k = 0; k < int'(RESP_LATENCY) + 2; k++) begin
            check("mid_no_resp", 64'(resp_valid), 64'd0);
            check("mid_ready", 64'(req_ready), 64'd1);
            @(negedge clk);
        end
        for (int r = 2; r < int'(NUM_REGS); r++) begin
            transact("mid_scr", BASE_ADDR + 12'(r), 64'd0, 3'd0, 1'b0, obs);
            check("mid_scr_zero", obs, 64'd0);
        end

        // Randomized requests around the bank window.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 7) == 0) a = 12'($urandom);
            else                           a = 12'h7BE + 12'($urandom_range(0, 11));
            transact("rand", a, {$urandom, $urandom}, 3'($urandom_range(0, 7)),
                     1'($urandom_range(0, 1)), obs);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
